rr_arb_mux: RTL
===============

Name: rr_arb_mux

Overview:
- Parametrised N-channel arbitrated multiplexer with a registered output stage.
- Generational successor to the fixed 4:1 gate-level selector used ahead of the FIFO write port.
- Selects among N valid/ready input streams using round-robin or fixed priority; presents one word per cycle to the FIFO write side together with its source channel index.
- Full throughput: one word per cycle under continuous demand, with backpressure honoured.

Parameters:
- WIDTH, 4: data width of each channel and of the output, in bits.
- NCH, 4: number of input channels; legal values 2..16.
- CHW, 2: channel index width; must equal ceil(log2(NCH)).
- RR_MODE, 1: 1 = round-robin arbitration; 0 = fixed priority, lowest index wins.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_data  input  NCH*WIDTH  packed channel data; channel k occupies bits [k*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel valid.
- in_ready  output  NCH  per-channel ready (combinational).
- out_data  output  WIDTH  registered selected word.
- out_chan  output  CHW  registered source channel index of out_data.
- out_valid  output  1  registered output valid.
- out_ready  input  1  downstream (FIFO write side) ready.

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low. Already decided.
- Reset values while rst_n=0: out_valid=0, out_data=0, out_chan=0, internal priority pointer ptr=0.
  - Reset asserted mid-transfer drops any held word immediately; no partial state survives.
  - First acceptance is possible on the first rising edge after rst_n deasserts.
- Load enable: load = ~out_valid | out_ready.
  - The output register is refilled in the same cycle it is drained, so there is no bubble.
- Grant (combinational, one-hot or zero):
  - RR_MODE=1: scan channels ptr, ptr+1, ..., NCH-1, 0, ..., ptr-1 (wrap modulo NCH); the first with in_valid=1 is granted.
  - RR_MODE=0: lowest index with in_valid=1 is granted; ptr has no effect.
  - No in_valid asserted: no grant.
- in_ready[k] = grant[k] & load.
  - At most one in_ready bit is high per cycle.
  - in_ready combinationally depends on out_ready and in_valid.
- Transfer on channel k occurs when in_valid[k] & in_ready[k] at a rising edge. Then:
  - out_data <= channel k data; out_chan <= k; out_valid <= 1.
  - RR_MODE=1: ptr <= (k+1) mod NCH. With NCH not a power of two, k = NCH-1 wraps ptr to 0.
  - RR_MODE=0: ptr is held at 0.
- No transfer and load=1: out_valid <= 0; out_data and out_chan hold their previous values (don't-care to the consumer).
- No transfer and load=0 (out_valid=1, out_ready=0): out_data, out_chan and out_valid are held stable. This is a stall.
  - Inputs are not sampled during a stall.
- Latency: input accept to out_valid = 1 cycle.
- Ordering: per channel, words leave in acceptance order.
- Fairness: with RR_MODE=1, each continuously-valid channel is granted at least once every NCH transfers.
- Input validity: in_valid may drop without a transfer. The block imposes no input stability requirement but does not hide glitches.
- ptr changes only on a transfer, never on a stall or an idle cycle.
- Simultaneous drain and fill: the old word is consumed and the new word captured at the same edge; out_valid stays 1.

Test Plan:
- Reset and idle: hold rst_n=0, then release with in_valid=0 -> out_valid=0, out_data=0, out_chan=0, in_ready=0 on every cycle.
- Round-robin streaming: RR_MODE=1, NCH=4; all in_valid=1, channel k data = 0xA+k; out_ready=1 throughout -> out_chan = 0,1,2,3,0,1 on consecutive cycles, out_data = A,B,C,D,A,B, no idle cycles.
- Backpressure: out_valid=1 with out_chan=2 and data 0xC; drive out_ready=0 for 3 cycles -> out_data/out_chan stable, in_ready=0000, ptr unchanged; on out_ready=1, next grant is channel 3.
- Wrap search: ptr=1 with only in_valid[0]=1 -> channel 0 granted, then ptr=1; next, only in_valid[3]=1 -> channel 3 granted, then ptr=0.
- Fixed priority: RR_MODE=0; in_valid=0101 held, out_ready=1 -> channel 0 granted every cycle, channel 2 never granted.
- Reset mid-stall: out_valid=1, out_ready=0; assert rst_n=0 between clock edges -> out_valid=0 immediately (before the next edge); after release, ptr=0 and channel 0 wins first when all channels are valid.

Source files
------------

// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - N-channel round-robin/fixed-priority arbitrated mux with registered output
module rr_arb_mux #(
  parameter int WIDTH   = 4,
  parameter int NCH     = 4,
  parameter int CHW     = 2,
  parameter int RR_MODE = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [CHW-1:0]       out_chan,
  output logic                 out_valid,
  input  logic                 out_ready
);

  logic [CHW-1:0]   ptr;
  logic [CHW-1:0]   gidx;
  logic [NCH-1:0]   grant;
  logic             found;
  logic             load;
  logic [WIDTH-1:0] sel_data;
  logic [CHW-1:0]   ptr_next;

  // Output register may be refilled in the same cycle it drains.
  assign load = ~out_valid | out_ready;

  always_comb begin : grant_scan
    int c;
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    c     = 0;
    for (int i = 0; i < NCH; i++) begin
      c = (RR_MODE != 0) ? (int'(ptr) + i) % NCH : i;
      if (!found && in_valid[CHW'(c)]) begin
        found             = 1'b1;
        grant[CHW'(c)]    = 1'b1;
        gidx              = CHW'(c);
      end
    end
  end

  assign in_ready = grant & {NCH{load}};
  assign sel_data = in_data[gidx*WIDTH +: WIDTH];
  assign ptr_next = (RR_MODE != 0) ? CHW'((int'(gidx) + 1) % NCH) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_chan  <= '0;
      ptr       <= '0;
    end else if (load) begin
      if (found) begin
        out_data  <= sel_data;
        out_chan  <= gidx;
        out_valid <= 1'b1;
        ptr       <= ptr_next;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
